// File: rtl/q_agent_driver.sv
// q_agent_driver
// Episode driver for a tabular Q-learning datapath. It owns an 8x8 grid world
// and an epsilon-greedy policy. Each step it issues one transition
// (s, a, s_next, reward) to the Q-update pipeline, then waits for the updated
// Q value. That value is mirrored into a local shadow Q-table, which drives
// greedy action selection.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   run_en                     level; keep stepping while high
//   new_Q_value, new_Q_valid   result returned by the update pipeline
//   s, a, s_next, reward       transition presented with update_en
//   update_en                  one-cycle transition strobe
//   busy                       FSM not idle
//   episode_done, timeout      one-cycle end-of-episode pulses
//   step_count, episode_count  progress counters
//
// Optional feature: define QAGENT_MAX_STEPS_EN to truncate episodes after
// MAX_STEPS steps. A truncated episode also pulses timeout.
module q_agent_driver #(
   parameter logic [5:0]         START_STATE  = 6'd0,
   parameter logic [5:0]         GOAL_STATE   = 6'd63,
   parameter logic [7:0]         EPSILON      = 8'd26,
   parameter logic [15:0]        LFSR_SEED    = 16'hACE1,
   parameter logic signed [15:0] GOAL_REWARD  = 16'sh0A00,
   parameter logic signed [15:0] STEP_PENALTY = 16'shFFE6,
   parameter logic signed [15:0] WALL_PENALTY = 16'shFF00,
   parameter logic [15:0]        MAX_STEPS    = 16'd256
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run_en,
   input  logic signed [15:0] new_Q_value,
   input  logic               new_Q_valid,
   output logic [5:0]         s,
   output logic [1:0]         a,
   output logic [5:0]         s_next,
   output logic signed [15:0] reward,
   output logic               update_en,
   output logic               busy,
   output logic               episode_done,
   output logic               timeout,
   output logic [15:0]        step_count,
   output logic [15:0]        episode_count
);

   typedef enum logic [1:0] {IDLE, SELECT, ISSUE, WAIT} state_t;

   state_t             r_state;
   logic [15:0]        r_lfsr;
   logic signed [15:0] r_shadow [64][4];
   logic [5:0]         r_s, r_s_next;
   logic [1:0]         r_a;
   logic signed [15:0] r_reward;
   logic               r_update_en, r_done, r_timeout;
   logic [15:0]        r_step, r_epc;

   logic [15:0]        w_lfsr_nx;
   logic [1:0]         w_best, w_act;
   logic signed [15:0] w_best_q;
   logic               w_wall;
   logic [2:0]         w_nrow, w_ncol;
   logic [5:0]         w_snx;
   logic signed [15:0] w_rew;
   logic               w_goal, w_trunc, w_end;

   // Fibonacci LFSR: taps 16,14,13,11, shift left, feedback into bit 0
   assign w_lfsr_nx = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

   // Greedy action. The strict '>' keeps the lowest index on ties.
   always_comb begin
      w_best   = 2'd0;
      w_best_q = r_shadow[r_s][0];
      for (int i = 1; i < 4; i++) begin
         if (r_shadow[r_s][i] > w_best_q) begin
            w_best   = 2'(i);
            w_best_q = r_shadow[r_s][i];
         end
      end
   end

   // Explore with the freshly advanced LFSR value
   assign w_act = (w_lfsr_nx[7:0] < EPSILON) ? w_lfsr_nx[9:8] : w_best;

   // Grid move: 0=up (row-1), 1=right (col+1), 2=down (row+1), 3=left (col-1)
   always_comb begin
      w_wall = 1'b0;
      w_nrow = r_s[5:3];
      w_ncol = r_s[2:0];
      case (w_act)
         2'd0: begin w_wall = (r_s[5:3] == 3'd0); w_nrow = r_s[5:3] - 3'd1; end
         2'd1: begin w_wall = (r_s[2:0] == 3'd7); w_ncol = r_s[2:0] + 3'd1; end
         2'd2: begin w_wall = (r_s[5:3] == 3'd7); w_nrow = r_s[5:3] + 3'd1; end
         default: begin w_wall = (r_s[2:0] == 3'd0); w_ncol = r_s[2:0] - 3'd1; end
      endcase
   end

   assign w_snx = w_wall ? r_s : {w_nrow, w_ncol};
   assign w_rew = w_wall ? WALL_PENALTY :
                  ((w_snx == GOAL_STATE) ? GOAL_REWARD : STEP_PENALTY);

   assign w_goal = (r_s_next == GOAL_STATE);
`ifdef QAGENT_MAX_STEPS_EN
   assign w_trunc = !w_goal && ((r_step + 16'd1) == MAX_STEPS);
`else
   logic w_unused_max;
   assign w_unused_max = ^MAX_STEPS;
   assign w_trunc      = 1'b0;
`endif
   assign w_end = w_goal | w_trunc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_lfsr      <= LFSR_SEED;
         r_s         <= START_STATE;
         r_a         <= 2'd0;
         r_s_next    <= 6'd0;
         r_reward    <= 16'sd0;
         r_update_en <= 1'b0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
         r_step      <= 16'd0;
         r_epc       <= 16'd0;
         for (int i = 0; i < 64; i++)
            for (int j = 0; j < 4; j++)
               r_shadow[i][j] <= 16'sd0;
      end else begin
         r_update_en <= 1'b0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
         case (r_state)
            IDLE: if (run_en) r_state <= SELECT;
            SELECT: begin
               r_lfsr      <= w_lfsr_nx;
               r_a         <= w_act;
               r_s_next    <= w_snx;
               r_reward    <= w_rew;
               r_update_en <= 1'b1;
               r_state     <= ISSUE;
            end
            ISSUE: r_state <= WAIT;
            default: begin
               if (new_Q_valid) begin
                  r_shadow[r_s][r_a] <= new_Q_value;
                  if (w_end) begin
                     r_done    <= 1'b1;
                     r_timeout <= w_trunc;
                     r_epc     <= r_epc + 16'd1;
                     r_step    <= 16'd0;
                     r_s       <= START_STATE;
                  end else begin
                     r_step <= r_step + 16'd1;
                     r_s    <= r_s_next;
                  end
                  // a dropped run_en takes effect only once the step is complete
                  r_state <= run_en ? SELECT : IDLE;
               end
            end
         endcase
      end
   end

   assign s             = r_s;
   assign a             = r_a;
   assign s_next        = r_s_next;
   assign reward        = r_reward;
   assign update_en     = r_update_en;
   assign busy          = (r_state != IDLE);
   assign episode_done  = r_done;
   assign timeout       = r_timeout;
   assign step_count    = r_step;
   assign episode_count = r_epc;

endmodule

// File: tb/tb_q_agent_driver.sv
module tb_q_agent_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int n_fin = 0;

   typedef struct packed {
      logic [5:0]  s;
      logic [1:0]  a;
      logic [5:0]  sn;
      logic [15:0] r;
      logic [15:0] sc;
      logic [15:0] ec;
   } xact_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp_v);
      end
   endtask

   // Five independent DUTs, each configured for a different scenario:
   //   0: EPSILON=0, pipeline always returns -1.0, reset asserted in WAIT
   //   1: START=8, GOAL=0, EPSILON=0, random Q values
   //   2: EPSILON=255, random Q values, continuous run (5-cycle spacing)
   //   3: EPSILON=0, MAX_STEPS=4, pipeline always returns 0
   //   4: default EPSILON, random Q values, random run_en drops, reset in WAIT
   for (genvar g = 0; g < 5; g++) begin : gi
      localparam logic [5:0]  ST     = (g == 1) ? 6'd8 : 6'd0;
      localparam logic [5:0]  GL     = (g == 1) ? 6'd0 : 6'd63;
      localparam logic [7:0]  EP     = (g == 2) ? 8'd255 : (g == 4) ? 8'd26 : 8'd0;
      localparam logic [15:0] MS     = (g == 3) ? 16'd4 : 16'd256;
      localparam int          NSTEP  = (g == 2) ? 200 : (g == 4) ? 300 : (g == 3) ? 100 : 60;
      localparam bit          RANDRUN = (g == 4);
      localparam bit          DORST   = (g == 0) || (g == 4);
      localparam int          RST_K   = (g == 0) ? 20 : 150;
      localparam bit          GAPCHK  = (g >= 1) && (g <= 3);

      logic               rst, run, qv;
      logic signed [15:0] qval;
      logic [5:0]         s, sn;
      logic [1:0]         a;
      logic signed [15:0] rw;
      logic               ue, busy, ed, to;
      logic [15:0]        sc, ec;

      q_agent_driver #(
         .START_STATE(ST), .GOAL_STATE(GL), .EPSILON(EP), .LFSR_SEED(16'hACE1),
         .GOAL_REWARD(16'sh0A00), .STEP_PENALTY(16'shFFE6), .WALL_PENALTY(16'shFF00),
         .MAX_STEPS(MS)
      ) dut (
         .clk(clk), .reset(rst), .run_en(run), .new_Q_value(qval), .new_Q_valid(qv),
         .s(s), .a(a), .s_next(sn), .reward(rw), .update_en(ue), .busy(busy),
         .episode_done(ed), .timeout(to), .step_count(sc), .episode_count(ec)
      );

      xact_t      expq [$];
      logic [1:0] doneq [$];

      // reference model state
      int m_q [64][4];
      int m_lfsr, m_s, m_steps, m_epc;
      int ca, csn, crw, nr, nc, fb;
      bit dn, tmo, got, post_rst, abort;
      xact_t xe;

      // Monitor: compares every presented transition and every end-of-episode pulse
      int cyc = 0;
      int last_ue = -1;
      initial begin
         xact_t x;
         logic [1:0] d;
         forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (ue) begin
               if (expq.size() == 0) begin
                  chk($sformatf("g%0d unexpected_update_en", g), 64'(1), 64'(0));
               end else begin
                  x = expq.pop_front();
                  chk($sformatf("g%0d xact{s,a,sn,r,sc,ec}", g), 64'(x), 64'({s, a, sn, rw, sc, ec}));
               end
               if (GAPCHK && last_ue >= 0)
                  chk($sformatf("g%0d update_en_spacing", g), 64'(cyc - last_ue), 64'(5));
               last_ue = cyc;
            end
            if (doneq.size() != 0) begin
               d = doneq.pop_front();
               chk($sformatf("g%0d done_timeout", g), 64'({ed, to}), 64'(d));
            end else if (ed || to) begin
               chk($sformatf("g%0d spurious_done_timeout", g), 64'({ed, to}), 64'(0));
            end
         end
      end

      // Stimulus, pipeline responder and reference model
      initial begin
         rst = 1'b0; run = 1'b0; qv = 1'b0; qval = 16'sd0;
         post_rst = 1'b0; abort = 1'b0;
         for (int i = 0; i < 64; i++) for (int j = 0; j < 4; j++) m_q[i][j] = 0;
         m_lfsr = 16'hACE1; m_s = ST; m_steps = 0; m_epc = 0;
         #1 rst = 1'b1;
         @(posedge clk); #1;
         chk($sformatf("g%0d reset_a", g), 64'({s, a, sn, rw, ue, busy, ed, to}), 64'({ST, 2'd0, 6'd0, 16'd0, 4'd0}));
         chk($sformatf("g%0d reset_b", g), 64'({sc, ec}), 64'(0));
         @(negedge clk); rst = 1'b0;

         for (int k = 0; k < NSTEP && !abort; k++) begin
            if (!run) begin @(negedge clk); run = 1'b1; end
            // predict the transition the DUT is about to select
            fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
            m_lfsr = ((m_lfsr << 1) & 16'hFFFF) | fb;
            if ((m_lfsr & 255) < int'(EP)) ca = (m_lfsr >> 8) & 3;
            else begin
               ca = 0;
               for (int i = 1; i < 4; i++) if (m_q[m_s][i] > m_q[m_s][ca]) ca = i;
            end
            nr = m_s / 8; nc = m_s % 8;
            case (ca)
               0: nr = nr - 1;
               1: nc = nc + 1;
               2: nr = nr + 1;
               default: nc = nc - 1;
            endcase
            if (nr < 0 || nr > 7 || nc < 0 || nc > 7) begin csn = m_s; crw = -256; end
            else begin csn = nr * 8 + nc; crw = (csn == int'(GL)) ? 2560 : -26; end
            xe.s = 6'(m_s); xe.a = 2'(ca); xe.sn = 6'(csn); xe.r = 16'(crw);
            xe.sc = 16'(m_steps); xe.ec = 16'(m_epc);
            expq.push_back(xe);

            got = 1'b0;
            for (int w = 0; w < 12 && !got; w++) begin @(negedge clk); got = ue; end
            if (!got) begin
               chk($sformatf("g%0d wait_update_en", g), 64'(0), 64'(1));
               abort = 1'b1;
               break;
            end
            if (g == 0 && k == 0) chk("g0 first_step", 64'({a, sn, rw}), 64'({2'd0, 6'd0, 16'hFF00}));
            if (g == 0 && k == 1) chk("g0 second_step", 64'({a, sn, rw}), 64'({2'd1, 6'd1, 16'hFFE6}));
            if (g == 1 && k == 0) chk("g1 goal_step", 64'({a, sn, rw}), 64'({2'd0, 6'd0, 16'h0A00}));
            if (post_rst) begin
               chk($sformatf("g%0d after_reset_a", g), 64'(a), 64'(0));
               post_rst = 1'b0;
            end
            if (RANDRUN) run = ($urandom_range(3) != 0);
            if (k == NSTEP - 1) run = 1'b0;

            if (DORST && k == RST_K) begin
               @(negedge clk); rst = 1'b1; run = 1'b0;
               @(posedge clk); #1;
               chk($sformatf("g%0d midreset_a", g), 64'({s, a, sn, rw, ue, busy, ed, to}), 64'({ST, 2'd0, 6'd0, 16'd0, 4'd0}));
               chk($sformatf("g%0d midreset_b", g), 64'({sc, ec}), 64'(0));
               expq.delete(); doneq.delete();
               for (int i = 0; i < 64; i++) for (int j = 0; j < 4; j++) m_q[i][j] = 0;
               m_lfsr = 16'hACE1; m_s = ST; m_steps = 0; m_epc = 0;
               @(negedge clk); rst = 1'b0;
               // late pipeline response must be ignored
               @(negedge clk); qv = 1'b1; qval = 16'sh7FFF;
               @(negedge clk); qv = 1'b0;
               @(negedge clk);
               chk($sformatf("g%0d late_valid_idle", g), 64'({busy, ec, sc}), 64'(0));
               post_rst = 1'b1;
               continue;
            end

            repeat (3) @(negedge clk);
            qv = 1'b1;
            qval = (g == 0) ? 16'shFF00 : (g == 3) ? 16'sd0 : 16'($urandom_range(65535));
            m_q[m_s][ca] = int'(qval);
            m_steps++;
            dn  = (csn == int'(GL));
            tmo = 1'b0;
`ifdef QAGENT_MAX_STEPS_EN
            tmo = !dn && (m_steps == int'(MS));
`endif
            if (dn || tmo) begin
               m_epc = (m_epc + 1) & 16'hFFFF; m_steps = 0; m_s = ST;
            end else m_s = csn;
            doneq.push_back({dn || tmo, tmo});
            @(negedge clk); qv = 1'b0;
            if (g == 1 && k == 0) chk("g1 after_goal", 64'({ed, ec, s, sc}), 64'({1'b1, 16'd1, 6'd8, 16'd0}));
`ifdef QAGENT_MAX_STEPS_EN
            if (g == 3 && k == 3) chk("g3 step4_timeout", 64'({ed, to}), 64'(2'b11));
`else
            if (g == 3 && k == 3) chk("g3 step4_no_timeout", 64'({ed, to}), 64'(2'b00));
`endif
            if (!run) chk($sformatf("g%0d idle_after_drop", g), 64'(busy), 64'(0));
         end

         run = 1'b0;
         repeat (10) @(negedge clk);
         chk($sformatf("g%0d pending_xact", g), 64'(expq.size()), 64'(0));
         chk($sformatf("g%0d pending_done", g), 64'(doneq.size()), 64'(0));
         n_fin++;
      end
   end

   initial begin
      for (int c = 0; c < 20000 && n_fin < 5; c++) @(posedge clk);
      if (n_fin < 5) chk("finish_budget", 64'(n_fin), 64'(5));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
